// File: rtl/uart_cmd_responder.sv
// UART command responder: decodes 'W' addr data / 'R' addr frames into register-bus strobes and replies over UART.
// Build option UART_CMD_CSUM_EN: trailing XOR checksum byte per frame and two-byte replies (reply, ~reply).
module uart_cmd_responder #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_ok,
  input  logic       rx_error,
  output logic [7:0] tx_data,
  output logic       tx_send,
  input  logic       tx_busy,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic [7:0] err_cnt
);

  localparam int         CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_OK  = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h45;

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    GET_ADDR   = 4'd1,
    GET_DATA   = 4'd2,
    GET_CSUM   = 4'd3,
    BUS_WR     = 4'd4,
    BUS_RD     = 4'd5,
    RD_CAP     = 4'd6,
    TX_REQ     = 4'd7,
    TX_WAIT_HI = 4'd8,
    TX_WAIT_LO = 4'd9
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] tmo_q;
  logic             is_wr_q;
  logic [7:0]       tx_data_q;
  logic             tx_send_q;
  logic [7:0]       reg_addr_q;
  logic [7:0]       reg_wdata_q;
  logic             reg_we_q;
  logic             reg_re_q;
  logic [7:0]       err_cnt_q;
`ifdef UART_CMD_CSUM_EN
  logic [7:0]       csum_q;
  logic             cmpl_sent_q;
`endif

  logic       rx_phase;
  logic       tmo_hit;
  logic       drop_byte;
  logic [7:0] err_cnt_d;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? 8'hFF : v + 8'h01;
  endfunction

  assign rx_phase  = (state_q == GET_ADDR) || (state_q == GET_DATA) || (state_q == GET_CSUM);
  assign tmo_hit   = rx_phase && !rx_ok && (tmo_q == CNT_W'(TIMEOUT_CYC - 1));
  assign drop_byte = rx_ok && !rx_phase && (state_q != IDLE);
  assign err_cnt_d = sat_inc(err_cnt_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tmo_q       <= {CNT_W{1'b0}};
      is_wr_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_send_q   <= 1'b0;
      reg_addr_q  <= 8'h00;
      reg_wdata_q <= 8'h00;
      reg_we_q    <= 1'b0;
      reg_re_q    <= 1'b0;
      err_cnt_q   <= 8'h00;
`ifdef UART_CMD_CSUM_EN
      csum_q      <= 8'h00;
      cmpl_sent_q <= 1'b0;
`endif
    end else begin
      tx_send_q <= 1'b0;
      reg_we_q  <= 1'b0;
      reg_re_q  <= 1'b0;

      // Inter-byte timer only runs while a frame is partially received
      if (rx_phase && !rx_ok && !tmo_hit) begin
        tmo_q <= tmo_q + CNT_W'(1);
      end else begin
        tmo_q <= {CNT_W{1'b0}};
      end

      if (drop_byte) begin
        err_cnt_q <= err_cnt_d;
      end

      if (tmo_hit) begin
        state_q   <= IDLE;
        err_cnt_q <= err_cnt_d;
      end else begin
        case (state_q)
          IDLE: begin
`ifdef UART_CMD_CSUM_EN
            cmpl_sent_q <= 1'b0;
            csum_q      <= rx_data;
`endif
            if (rx_ok) begin
              if (!rx_error && ((rx_data == OP_WR) || (rx_data == OP_RD))) begin
                is_wr_q <= (rx_data == OP_WR);
                state_q <= GET_ADDR;
              end else begin
                tx_data_q <= RSP_ERR;
                err_cnt_q <= err_cnt_d;
                state_q   <= TX_REQ;
              end
            end
          end
          GET_ADDR: begin
            if (rx_ok) begin
              if (rx_error) begin
                tx_data_q <= RSP_ERR;
                err_cnt_q <= err_cnt_d;
                state_q   <= TX_REQ;
              end else begin
                reg_addr_q <= rx_data;
`ifdef UART_CMD_CSUM_EN
                csum_q  <= csum_q ^ rx_data;
                state_q <= is_wr_q ? GET_DATA : GET_CSUM;
`else
                if (is_wr_q) begin
                  state_q <= GET_DATA;
                end else begin
                  reg_re_q <= 1'b1;
                  state_q  <= BUS_RD;
                end
`endif
              end
            end
          end
          GET_DATA: begin
            if (rx_ok) begin
              if (rx_error) begin
                tx_data_q <= RSP_ERR;
                err_cnt_q <= err_cnt_d;
                state_q   <= TX_REQ;
              end else begin
                reg_wdata_q <= rx_data;
`ifdef UART_CMD_CSUM_EN
                csum_q  <= csum_q ^ rx_data;
                state_q <= GET_CSUM;
`else
                reg_we_q <= 1'b1;
                state_q  <= BUS_WR;
`endif
              end
            end
          end
`ifdef UART_CMD_CSUM_EN
          GET_CSUM: begin
            if (rx_ok) begin
              if (rx_error || (rx_data != csum_q)) begin
                tx_data_q <= RSP_ERR;
                err_cnt_q <= err_cnt_d;
                state_q   <= TX_REQ;
              end else if (is_wr_q) begin
                reg_we_q <= 1'b1;
                state_q  <= BUS_WR;
              end else begin
                reg_re_q <= 1'b1;
                state_q  <= BUS_RD;
              end
            end
          end
`endif
          BUS_WR: begin
            tx_data_q <= RSP_OK;
            state_q   <= TX_REQ;
          end
          BUS_RD: begin
            state_q <= RD_CAP;
          end
          RD_CAP: begin
            tx_data_q <= reg_rdata;
            state_q   <= TX_REQ;
          end
          TX_REQ: begin
            if (!tx_busy) begin
              tx_send_q <= 1'b1;
              state_q   <= TX_WAIT_HI;
            end
          end
          TX_WAIT_HI: begin
            if (tx_busy) begin
              state_q <= TX_WAIT_LO;
            end
          end
          TX_WAIT_LO: begin
            if (!tx_busy) begin
`ifdef UART_CMD_CSUM_EN
              // Second reply byte is the complement of the first
              if (!cmpl_sent_q) begin
                tx_data_q   <= ~tx_data_q;
                cmpl_sent_q <= 1'b1;
                state_q     <= TX_REQ;
              end else begin
                state_q <= IDLE;
              end
`else
              state_q <= IDLE;
`endif
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_send   = tx_send_q;
  assign reg_addr  = reg_addr_q;
  assign reg_wdata = reg_wdata_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: randomized frames, frame-level reference model,
// decoupled monitors for register strobes and UART replies.
module tb_uart_cmd_responder;

  localparam int TMO = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_ok = 1'b0;
  logic       rx_error = 1'b0;
  logic [7:0] tx_data;
  logic       tx_send;
  logic       tx_busy = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic [7:0] err_cnt;

  always #5 clk = ~clk;

  uart_cmd_responder #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_ok(rx_ok), .rx_error(rx_error),
    .tx_data(tx_data), .tx_send(tx_send), .tx_busy(tx_busy),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .err_cnt(err_cnt)
  );

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] data;
  } bus_t;
  typedef logic [7:0] bq_t[$];

  logic [7:0] exp_tx[$];
  bus_t       exp_bus[$];
  logic [7:0] mem[256];
  logic [7:0] ref_regs[256];
  int n_cmp = 0;
  int n_bad = 0;
  int err_model = 0;
  int cyc = 0;
  int last_rx_cyc = 0;
  int uart_delay = 1;
  bit uart_active = 1'b0;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic err_inc();
    err_model = (err_model == 255) ? 255 : err_model + 1;
  endtask

  task automatic push_reply(input logic [7:0] r);
    exp_tx.push_back(r);
`ifdef UART_CMD_CSUM_EN
    exp_tx.push_back(~r);
`endif
  endtask

  function automatic int frame_len(input logic [7:0] op);
`ifdef UART_CMD_CSUM_EN
    return (op == 8'h57) ? 4 : 3;
`else
    return (op == 8'h57) ? 3 : 2;
`endif
  endfunction

  function automatic bq_t make_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d);
    bq_t f;
`ifdef UART_CMD_CSUM_EN
    logic [7:0] x;
`endif
    f.push_back(op);
    f.push_back(a);
    if (op == 8'h57) f.push_back(d);
`ifdef UART_CMD_CSUM_EN
    x = 8'h00;
    foreach (f[i]) x ^= f[i];
    f.push_back(x);
`endif
    return f;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Register-file slave: read data is valid only in the cycle after reg_re, junk otherwise
  initial begin
    bit         rd_pend = 1'b0;
    logic [7:0] rd_addr = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (rd_pend) begin
        reg_rdata = mem[rd_addr];
        rd_pend   = 1'b0;
      end else begin
        reg_rdata = 8'($urandom);
      end
      if (reg_we) mem[reg_addr] = reg_wdata;
      if (reg_re) begin
        rd_pend = 1'b1;
        rd_addr = reg_addr;
      end
    end
  end

  // UART transmitter model
  initial forever begin
    @(negedge clk);
    if (tx_send) begin
      uart_active = 1'b1;
      repeat (uart_delay) @(posedge clk);
      #1 tx_busy = 1'b1;
      repeat ($urandom_range(4, 7)) @(posedge clk);
      #1 tx_busy = 1'b0;
      uart_active = 1'b0;
    end
  end

  // Monitor: compares every strobe and transmit request against the scoreboard queues
  initial forever begin
    bus_t e;
    logic [7:0] t;
    @(negedge clk);
    if (reg_we || reg_re) begin
      check8("we_re_exclusive", {7'b0, reg_we & reg_re}, 8'h00);
      if (exp_bus.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_strobe: got we=%0b re=%0b addr=%02h expected none", reg_we, reg_re, reg_addr);
      end else begin
        e = exp_bus.pop_front();
        check8("strobe_kind", {7'b0, reg_we}, {7'b0, e.we});
        check8("reg_addr", reg_addr, e.addr);
        if (e.we) check8("reg_wdata", reg_wdata, e.data);
        check8("strobe_latency", 8'(cyc - last_rx_cyc), 8'd1);
      end
    end
    if (tx_send) begin
      if (exp_tx.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_tx: got %02h expected none", tx_data);
      end else begin
        t = exp_tx.pop_front();
        check8("tx_data", tx_data, t);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic e);
    @(posedge clk);
    #1;
    rx_data = b;
    rx_ok = 1'b1;
    rx_error = e;
    last_rx_cyc = cyc;
    @(posedge clk);
    #1;
    rx_ok = 1'b0;
    rx_error = 1'($urandom);
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, 3)) @(posedge clk);
  endtask

  task automatic send_frame(input bq_t f, input int err_pos, input int n);
    for (int i = 0; i < n; i++) send_byte(f[i], (i == err_pos));
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    bq_t f;
    exp_bus.push_back('{1'b1, a, d});
    ref_regs[a] = d;
    push_reply(8'h4B);
    f = make_frame(8'h57, a, d);
    send_frame(f, -1, f.size());
  endtask

  task automatic do_read(input logic [7:0] a);
    bq_t f;
    exp_bus.push_back('{1'b0, a, 8'h00});
    push_reply(ref_regs[a]);
    f = make_frame(8'h52, a, 8'h00);
    send_frame(f, -1, f.size());
  endtask

  task automatic do_badop(input logic [7:0] op);
    push_reply(8'h45);
    err_inc();
    send_byte(op, 1'b0);
  endtask

  task automatic do_rxerr(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d, input int pos);
    push_reply(8'h45);
    err_inc();
    send_frame(make_frame(op, a, d), pos, pos + 1);
  endtask

  task automatic do_timeout(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d, input int n);
    err_inc();
    send_frame(make_frame(op, a, d), -1, n);
    repeat (TMO + 10) @(posedge clk);
  endtask

  task automatic do_read_drop(input logic [7:0] a);
    int k = 0;
    do_read(a);
    while (!tx_busy && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (!tx_busy) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drop_wait: got no tx_busy expected busy within 500 cycles");
    end else begin
      err_inc();
      send_byte(8'($urandom), 1'($urandom));
    end
  endtask

`ifdef UART_CMD_CSUM_EN
  task automatic do_badcsum(input logic [7:0] a, input logic [7:0] d, input logic [7:0] mask);
    bq_t f;
    push_reply(8'h45);
    err_inc();
    f = make_frame(8'h57, a, d);
    f[f.size() - 1] = f[f.size() - 1] ^ mask;
    send_frame(f, -1, f.size());
  endtask
`endif

  task automatic wait_idle();
    int k = 0;
    while ((exp_tx.size() != 0 || uart_active || tx_busy) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    if (k >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL idle_timeout: got %0d replies outstanding expected 0", exp_tx.size());
      exp_tx.delete();
    end
    repeat (3) @(posedge clk);
    check8("bus_pending", 8'(exp_bus.size()), 8'h00);
    exp_bus.delete();
  endtask

  task automatic check_err();
    @(negedge clk);
    check8("err_cnt", err_cnt, 8'(err_model));
  endtask

  task automatic check_reset_outputs();
    @(negedge clk);
    check8("rst_tx_send", {7'b0, tx_send}, 8'h00);
    check8("rst_reg_we", {7'b0, reg_we}, 8'h00);
    check8("rst_reg_re", {7'b0, reg_re}, 8'h00);
    check8("rst_tx_data", tx_data, 8'h00);
    check8("rst_reg_addr", reg_addr, 8'h00);
    check8("rst_reg_wdata", reg_wdata, 8'h00);
    check8("rst_err_cnt", err_cnt, 8'h00);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] op;
    logic [7:0] a;
    logic [7:0] d;
    int k;
    for (int i = 0; i < 256; i++) begin
      d = 8'($urandom);
      mem[i] = d;
      ref_regs[i] = d;
    end
    repeat (3) @(posedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1 rst = 1'b0;

    // Directed scenarios
    do_write(8'h10, 8'hA5);
    wait_idle();
    check_err();
    mem[8'h10] = 8'h3C;
    ref_regs[8'h10] = 8'h3C;
    do_read(8'h10);
    wait_idle();
    check_err();
    do_badop(8'h41);
    wait_idle();
    check_err();
    do_rxerr(8'h57, 8'h10, 8'h00, 1);
    wait_idle();
    check_err();
    do_timeout(8'h57, 8'h10, 8'h00, 2);
    wait_idle();
    check_err();
    do_read(8'h10);
    wait_idle();
    check_err();
`ifdef UART_CMD_CSUM_EN
    do_write(8'h10, 8'hA5);
    wait_idle();
    do_badcsum(8'h10, 8'hA5, 8'hE2);
    wait_idle();
    check_err();
`endif

    // Reset while waiting for the transmitter to go busy on a write reply
    uart_delay = 6;
    exp_bus.push_back('{1'b1, 8'h22, 8'h5A});
    ref_regs[8'h22] = 8'h5A;
    exp_tx.push_back(8'h4B);
    send_frame(make_frame(8'h57, 8'h22, 8'h5A), -1, frame_len(8'h57));
    k = 0;
    while (!tx_send && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    err_model = 0;
    check_reset_outputs();
    wait_idle();
    repeat (10) @(posedge clk);
    check_err();
    uart_delay = 1;

    // Randomized traffic
    for (int n = 0; n < 60; n++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      op = ($urandom_range(0, 1) == 0) ? 8'h57 : 8'h52;
      case ($urandom_range(0, 7))
        0, 1: do_write(a, d);
        2: do_read(a);
        3: begin
          op = 8'($urandom);
          while (op == 8'h57 || op == 8'h52) op = 8'($urandom);
          do_badop(op);
        end
        4: do_rxerr(op, a, d, $urandom_range(1, frame_len(op) - 1));
        5: do_timeout(op, a, d, $urandom_range(1, frame_len(op) - 1));
        6: do_read_drop(a);
`ifdef UART_CMD_CSUM_EN
        default: do_badcsum(a, d, 8'($urandom_range(1, 255)));
`else
        default: do_read(a);
`endif
      endcase
      wait_idle();
      check_err();
    end

    // Saturation of the error counter
    for (int n = 0; n < 260; n++) begin
      do_badop(8'h00);
      wait_idle();
    end
    check_err();
    do_rxerr(8'h52, 8'h01, 8'h00, 1);
    wait_idle();
    check_err();
    do_read(8'h10);
    wait_idle();
    check_err();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
